// File: rtl/sifive_reset_sequencer.sv
// Staged reset sequencer: a debounced request level or a software pulse holds
// every channel in reset, then channels are released one stage at a time.
module sifive_reset_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int STAGE_DELAY = 256,
  parameter int FILTER      = 4,
  parameter int GRACEFUL    = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_in,
  input  logic                sw_req,
  output logic [CHANNELS-1:0] rst_out,
  output logic                ready,
  output logic                busy
);

  localparam int CW = $clog2(STAGE_DELAY + 1);
  localparam int IW = $clog2(CHANNELS + 1);
  localparam int FW = $clog2(FILTER + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(STAGE_DELAY - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(CHANNELS - 1);
  localparam logic [IW-1:0] IDX_ALL   = IW'(CHANNELS);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("sifive_reset_sequencer: CHANNELS must be >= 1");
  end
  if (STAGE_DELAY < 1) begin : g_bad_stage_delay
    $error("sifive_reset_sequencer: STAGE_DELAY must be >= 1");
  end
  if (FILTER < 1) begin : g_bad_filter
    $error("sifive_reset_sequencer: FILTER must be >= 1");
  end

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  state_e               abort_state_s;
  logic                 filt_q, filt_d;
  logic [FW-1:0]        fcnt_q, fcnt_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        abort_idx_s;
  logic                 request_s;
  logic [CHANNELS-1:0]  rst_out_q;
  logic                 ready_q;
  logic                 busy_q;

  // idx counts released channels; channel k is asserted while k >= idx.
  function automatic logic [CHANNELS-1:0] asserted_mask(input logic [IW-1:0] released);
    logic [CHANNELS-1:0] m;
    m = '1;
    for (int k = 0; k < CHANNELS; k++) begin
      m[k] = (k >= int'(released));
    end
    return m;
  endfunction

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (req_in != filt_q) begin
      if (fcnt_q == FILT_LAST) begin
        filt_d = req_in;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end else begin
      fcnt_d = '0;
    end
  end

  // The request sees the level the filter accepts on this very edge.
  assign request_s = filt_d | sw_req;

  always_comb begin
    abort_state_s = HOLD;
    abort_idx_s   = '0;
    if (GRACEFUL != 0) begin
      abort_idx_s = idx_q - IDX_ONE;
      if (idx_q > IDX_ONE) begin
        abort_state_s = DRAIN;
      end else begin
        abort_state_s = HOLD;
      end
    end else begin
      abort_state_s = HOLD;
      abort_idx_s   = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      HOLD: begin
        idx_d = '0;
        if (request_s || filt_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          idx_d = IDX_ONE;
          if (CHANNELS == 1) begin
            state_d = RUN;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (request_s) begin
          cnt_d   = '0;
          idx_d   = abort_idx_s;
          state_d = abort_state_s;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (request_s) begin
          idx_d   = abort_idx_s;
          state_d = abort_state_s;
        end else begin
          idx_d   = IDX_ALL;
          state_d = RUN;
        end
      end
      DRAIN: begin
        // Requests are deliberately ignored until the drain reaches channel 0.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          idx_d = idx_q - IDX_ONE;
          if (idx_q == IDX_ONE) begin
            state_d = HOLD;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= HOLD;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= asserted_mask(idx_d);
      ready_q   <= (idx_d == IDX_ALL);
      busy_q    <= (state_d == RELEASE) || (state_d == DRAIN);
    end
  end

  assign rst_out = rst_out_q;
  assign ready   = ready_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sifive_reset_sequencer.sv
// Bench for sifive_reset_sequencer: three configurations share one stimulus
// stream and are checked every cycle against a released-count reference model.
module tb_sifive_reset_sequencer;

  localparam int P_CH [3] = '{3, 3, 1};
  localparam int P_SD [3] = '{8, 8, 1};
  localparam int P_F  [3] = '{4, 4, 1};
  localparam int P_G  [3] = '{0, 1, 0};

  logic       clock;
  logic       reset;
  logic       req_in;
  logic       sw_req;
  logic [2:0] rst_a;
  logic [2:0] rst_b;
  logic [0:0] rst_c;
  logic       ready_a, ready_b, ready_c;
  logic       busy_a, busy_b, busy_c;

  int n_cmp;
  int n_bad;
  int edge_n;

  // Reference model: released-channel count plus a drain flag per instance.
  int m_filt  [3];
  int m_run   [3];
  int m_rel   [3];
  int m_since [3];
  bit m_drain [3];

  sifive_reset_sequencer #(.CHANNELS(3), .STAGE_DELAY(8), .FILTER(4), .GRACEFUL(0)) u_a (
    .clock(clock), .reset(reset), .req_in(req_in), .sw_req(sw_req),
    .rst_out(rst_a), .ready(ready_a), .busy(busy_a));
  sifive_reset_sequencer #(.CHANNELS(3), .STAGE_DELAY(8), .FILTER(4), .GRACEFUL(1)) u_b (
    .clock(clock), .reset(reset), .req_in(req_in), .sw_req(sw_req),
    .rst_out(rst_b), .ready(ready_b), .busy(busy_b));
  sifive_reset_sequencer #(.CHANNELS(1), .STAGE_DELAY(1), .FILTER(1), .GRACEFUL(0)) u_c (
    .clock(clock), .reset(reset), .req_in(req_in), .sw_req(sw_req),
    .rst_out(rst_c), .ready(ready_c), .busy(busy_c));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic string inst_name(input int i);
    case (i)
      0:       return "A";
      1:       return "B";
      default: return "C";
    endcase
  endfunction

  function automatic logic [2:0] act_rst(input int i);
    case (i)
      0:       return rst_a;
      1:       return rst_b;
      default: return {2'b00, rst_c};
    endcase
  endfunction

  function automatic logic act_ready(input int i);
    case (i)
      0:       return ready_a;
      1:       return ready_b;
      default: return ready_c;
    endcase
  endfunction

  function automatic logic act_busy(input int i);
    case (i)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic [2:0] exp_rst(input int i);
    logic [2:0] m;
    m = 3'b000;
    for (int k = 0; k < P_CH[i]; k++) begin
      m[k] = (k >= m_rel[i]);
    end
    return m;
  endfunction

  function automatic logic exp_ready(input int i);
    return (m_rel[i] == P_CH[i]);
  endfunction

  function automatic logic exp_busy(input int i);
    return m_drain[i] || ((m_rel[i] > 0) && (m_rel[i] < P_CH[i]));
  endfunction

  task automatic model_step(input int i, input bit rst_v, input bit req_v, input bit sw_v);
    int old_filt;
    bit want;
    if (rst_v) begin
      m_filt[i]  = 1;
      m_run[i]   = 0;
      m_rel[i]   = 0;
      m_since[i] = 0;
      m_drain[i] = 1'b0;
      return;
    end
    old_filt = m_filt[i];
    if (int'(req_v) != m_filt[i]) begin
      m_run[i]++;
      if (m_run[i] == P_F[i]) begin
        m_filt[i] = int'(req_v);
        m_run[i]  = 0;
      end
    end else begin
      m_run[i] = 0;
    end
    want = (m_filt[i] == 1) || sw_v;
    if (m_drain[i]) begin
      m_since[i]++;
      if (m_since[i] == P_SD[i]) begin
        m_since[i] = 0;
        m_rel[i]--;
        if (m_rel[i] == 0) m_drain[i] = 1'b0;
      end
    end else if (m_rel[i] == 0) begin
      if (want || old_filt == 1) begin
        m_since[i] = 0;
      end else begin
        m_since[i]++;
        if (m_since[i] == P_SD[i]) begin
          m_since[i] = 0;
          m_rel[i]   = 1;
        end
      end
    end else if (want) begin
      m_since[i] = 0;
      if (P_G[i] != 0) begin
        m_rel[i]--;
        m_drain[i] = (m_rel[i] > 0);
      end else begin
        m_rel[i] = 0;
      end
    end else if (m_rel[i] < P_CH[i]) begin
      m_since[i]++;
      if (m_since[i] == P_SD[i]) begin
        m_since[i] = 0;
        m_rel[i]++;
      end
    end else begin
      m_since[i] = 0;
    end
  endtask

  task automatic cmp(input string what, input logic [2:0] act, input logic [2:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at edge %0d: actual %b required %b", what, edge_n, act, req);
    end
  endtask

  // One rising edge: advance the model, then compare every instance on the falling edge.
  task automatic tick();
    @(posedge clock);
    for (int i = 0; i < 3; i++) model_step(i, reset, req_in, sw_req);
    edge_n++;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      cmp({inst_name(i), ".rst_out"}, act_rst(i), exp_rst(i));
      cmp({inst_name(i), ".ready"}, {2'b00, act_ready(i)}, {2'b00, exp_ready(i)});
      cmp({inst_name(i), ".busy"}, {2'b00, act_busy(i)}, {2'b00, exp_busy(i)});
    end
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  // Hand-computed expectation, applied to both the DUT and the model.
  task automatic pin(input int i, input logic [2:0] rst_e, input logic rdy_e, input logic busy_e);
    cmp({inst_name(i), ".rst_out pinned"}, act_rst(i), rst_e);
    cmp({inst_name(i), ".ready pinned"}, {2'b00, act_ready(i)}, {2'b00, rdy_e});
    cmp({inst_name(i), ".busy pinned"}, {2'b00, act_busy(i)}, {2'b00, busy_e});
    cmp({inst_name(i), ".model rst_out pinned"}, exp_rst(i), rst_e);
  endtask

  initial begin
    int p;
    int r;
    int len;
    n_cmp  = 0;
    n_bad  = 0;
    edge_n = -1;
    for (int i = 0; i < 3; i++) begin
      m_filt[i] = 1; m_run[i] = 0; m_rel[i] = 0; m_since[i] = 0; m_drain[i] = 1'b0;
    end
    reset  = 1'b1;
    req_in = 1'b1;
    sw_req = 1'b0;
    tick();
    pin(0, 3'b111, 1'b0, 1'b0);
    pin(2, 3'b001, 1'b0, 1'b0);

    // Release sequence from reset.
    reset  = 1'b0;
    req_in = 1'b0;
    run_to(1);  pin(2, 3'b001, 1'b0, 1'b0);
    run_to(2);  pin(2, 3'b000, 1'b1, 1'b0);
    run_to(11); pin(0, 3'b111, 1'b0, 1'b0);
    run_to(12); pin(0, 3'b110, 1'b0, 1'b1); pin(1, 3'b110, 1'b0, 1'b1);
    run_to(19); pin(0, 3'b110, 1'b0, 1'b1);
    run_to(20); pin(0, 3'b100, 1'b0, 1'b1);
    run_to(27); pin(0, 3'b100, 1'b0, 1'b1);
    run_to(28); pin(0, 3'b000, 1'b1, 1'b0); pin(1, 3'b000, 1'b1, 1'b0);

    // Runt rejection, then an accepted request.
    run_to(40);
    req_in = 1'b1;
    run_to(43); pin(0, 3'b000, 1'b1, 1'b0);
    req_in = 1'b0;
    run_to(50);
    req_in = 1'b1;
    run_to(53); pin(0, 3'b000, 1'b1, 1'b0);
    run_to(54); pin(0, 3'b111, 1'b0, 1'b0); pin(1, 3'b100, 1'b0, 1'b1);
    req_in = 1'b0;

    // Software pulse in RUN: full re-release on A, graceful drain on B.
    run_to(100);
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    p = edge_n;
    pin(0, 3'b111, 1'b0, 1'b0); pin(1, 3'b100, 1'b0, 1'b1); pin(2, 3'b001, 1'b0, 1'b0);
    run_to(p + 7);  pin(0, 3'b111, 1'b0, 1'b0); pin(1, 3'b100, 1'b0, 1'b1);
    run_to(p + 8);  pin(0, 3'b110, 1'b0, 1'b1); pin(1, 3'b110, 1'b0, 1'b1);
    run_to(p + 15); pin(1, 3'b110, 1'b0, 1'b1);
    run_to(p + 16); pin(1, 3'b111, 1'b0, 1'b0);
    run_to(p + 23); pin(0, 3'b100, 1'b0, 1'b1);
    run_to(p + 24); pin(0, 3'b000, 1'b1, 1'b0);
    run_to(p + 60);

    // Abort mid-release by filtered request, then by reset.
    reset = 1'b1;
    tick();
    r = edge_n;
    reset = 1'b0;
    run_to(r + 13);
    req_in = 1'b1;
    run_to(r + 16); pin(0, 3'b110, 1'b0, 1'b1); pin(1, 3'b110, 1'b0, 1'b1);
    run_to(r + 17); pin(0, 3'b111, 1'b0, 1'b0); pin(1, 3'b111, 1'b0, 1'b0);
    req_in = 1'b0;
    run_to(r + 30); pin(0, 3'b110, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    pin(0, 3'b111, 1'b0, 1'b0); pin(1, 3'b111, 1'b0, 1'b0); pin(2, 3'b001, 1'b0, 1'b0);
    reset = 1'b0;

    // Randomized segments of held levels with sparse pulses and resets.
    for (int s = 0; s < 150; s++) begin
      req_in = ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0;
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        sw_req = ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0;
        reset  = ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0;
        tick();
      end
    end
    sw_req = 1'b0;
    reset  = 1'b0;
    req_in = 1'b0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sifive_reset_sequencer.md
SIFIVE_RESET_SEQUENCER -- requirements
Module: sifive_reset_sequencer

Interface
REQ-001 Parameters SHALL be:
  - CHANNELS, default 4: number of sequenced reset outputs; legal range >= 1.
  - STAGE_DELAY, default 256: clock cycles between stage events; legal range >= 1.
  - FILTER, default 4: consecutive cycles req_in must hold a new level before it is accepted; legal range >= 1.
  - GRACEFUL, default 0: 0 = all outputs assert together; 1 = outputs assert in reverse order.
REQ-002 Ports SHALL be:
  - clock  in  1  sole clock; all logic uses its rising edge.
  - reset  in  1  synchronous, active-high reset.
  - req_in  in  1  reset-request level, already synchronous to clock.
  - sw_req  in  1  single-cycle pulse requesting a full reset cycle.
  - rst_out  out  CHANNELS  active-high resets; channel k is released after channel k-1.
  - ready  out  1  high only when every rst_out bit is low.
  - busy  out  1  high in the RELEASE and DRAIN states.
REQ-003 Elaboration SHALL fail if CHANNELS < 1, STAGE_DELAY < 1 or FILTER < 1.
REQ-004 The stage counter SHALL be $clog2(STAGE_DELAY+1) bits wide; the channel index SHALL be $clog2(CHANNELS+1) bits wide.

Function
REQ-005 Filter: register filt starts at 1; its counter increments while req_in != filt and clears while req_in == filt.
REQ-006 filt SHALL take the value of req_in on the FILTER-th consecutive edge that samples the differing level; the filter counter then clears.
REQ-007 Request SHALL be filt OR sw_req; sw_req is sampled on the edge where it is high and is never held pending.
REQ-008 States SHALL be HOLD, RELEASE, RUN and DRAIN.
REQ-009 HOLD: all rst_out = 1, ready = 0, busy = 0; the counter advances only while filt = 0 and clears when filt = 1 or sw_req = 1.
REQ-010 HOLD: on the STAGE_DELAY-th counting edge, rst_out[0] SHALL go to 0 and the counter clears.
  - If CHANNELS = 1, the next state is RUN with ready = 1.
  - Otherwise, the next state is RELEASE with index = 1.
REQ-011 RELEASE: every STAGE_DELAY edges, rst_out[index] SHALL go to 0 and index increments.
  - On the edge that releases channel CHANNELS-1, the state becomes RUN and ready = 1 on that same edge.
REQ-012 Release timing: for req_in falling with filt = 0 reached on edge E, rst_out[k] SHALL fall on edge E + (k+1)*STAGE_DELAY.
REQ-013 RUN: the counter is idle and outputs are held; on request, ready SHALL go to 0 on that edge.
REQ-014 Request in RUN or RELEASE with GRACEFUL = 0: all rst_out SHALL go to 1 on that edge; the state becomes HOLD and the counter clears.
REQ-015 Request in RUN or RELEASE with GRACEFUL = 1:
  - On that edge, the highest currently released channel SHALL go to 1 and the state becomes DRAIN.
  - If no channel is yet released, the state goes directly to HOLD.
REQ-016 DRAIN: every STAGE_DELAY edges, the next lower released channel SHALL go to 1.
  - On the edge that asserts channel 0, the state becomes HOLD with the counter cleared.
  - Further requests during DRAIN are ignored.
REQ-017 Invariant: rst_out SHALL always be of the form 1...10...0, with the high bits asserted; no channel k is ever released while channel k-1 is asserted.
REQ-018 Simultaneous request and release on the same edge: the request wins and the release does not occur.
REQ-019 busy SHALL be 1 exactly in the RELEASE and DRAIN states.

Reset
REQ-020 With reset high on an edge, the block SHALL take these values on that edge, regardless of state:
  - state = HOLD; rst_out = all 1s; ready = 0; busy = 0;
  - filt = 1; counters = 0; index = 0.
REQ-021 Reset asserted mid-RELEASE or mid-DRAIN SHALL abort the sequence with no partial release remaining.

Verification
REQ-022 The bench SHALL cover these scenarios, with CHANNELS = 3, STAGE_DELAY = 8, FILTER = 4 and GRACEFUL = 0 unless noted:
  - Release sequence: reset, then req_in = 0 from edge 1 -> rst_out[0] falls at edge 12, rst_out[1] at 20, rst_out[2] at 28; ready = 1 at edge 28; busy = 1 on edges 12-27.
  - Runt rejection: in RUN, req_in high for 3 cycles -> no change to rst_out or ready; high for 4 cycles -> rst_out = 3'b111 and ready = 0 on the 4th edge.
  - sw_req in RUN: 1-cycle pulse -> rst_out = 3'b111 on that edge; full re-release of all three channels completes after 24 edges.
  - Graceful drain: GRACEFUL = 1, sw_req in RUN -> rst_out[2] rises immediately, rst_out[1] 8 edges later, rst_out[0] 16 edges later; state returns to HOLD.
  - Abort mid-sequence: req_in re-asserted (filtered) after rst_out[0] is released -> with GRACEFUL = 0, all outputs = 1 at once; reset pulse in RELEASE -> all outputs = 1 on the next edge.
  - Edge cases: CHANNELS = 1, STAGE_DELAY = 1, FILTER = 1 -> rst_out falls 2 edges after req_in falls; ready rises on the same edge.
